// File: rtl/bcd_time_pkg.sv
// Shared constants and BCD helpers for the cascaded time counter.
// Every field value is one byte, packed as {tens, ones}.
package bcd_time_pkg;

  localparam logic [7:0] FIELD_MAX_BCD = 8'h59;
  localparam logic [7:0] BCD_ZERO      = 8'h00;

  typedef enum logic [1:0] {
    SEC = 2'd0,
    MIN = 2'd1,
    HR  = 2'd2
  } field_idx_e;

  // Converts an elaboration-time decimal value (0..99) to packed BCD.
  function automatic logic [7:0] to_bcd(input int unsigned value);
    logic [7:0] r_res;
    r_res[7:4] = 4'((value / 10) % 10);
    r_res[3:0] = 4'(value % 10);
    return r_res;
  endfunction

  function automatic logic bcd_valid(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Increments v; the value after max is zero.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r_res;
    if (v == max) begin
      r_res = BCD_ZERO;
    end else if (v[3:0] == 4'd9) begin
      r_res = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r_res = v + 8'd1;
    end
    return r_res;
  endfunction

  // Decrements v; the value before zero is max.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r_res;
    if (v == BCD_ZERO) begin
      r_res = max;
    end else if (v[3:0] == 4'd0) begin
      r_res = {v[7:4] - 4'd1, 4'd9};
    end else begin
      r_res = v - 8'd1;
    end
    return r_res;
  endfunction

  // Invalid BCD or an out-of-range value saturates to max. For valid BCD
  // the byte comparison orders the same way as the decimal value.
  function automatic logic [7:0] bcd_clamp(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r_res;
    if (!bcd_valid(v) || (v > max)) begin
      r_res = max;
    end else begin
      r_res = v;
    end
    return r_res;
  endfunction

endpackage

// File: rtl/bcd_field.sv
// One two-digit BCD register (0..MAX) with load, increment and decrement.
// carry/borrow flag that a step in that direction would roll this field over.
module bcd_field
  import bcd_time_pkg::*;
#(
  parameter logic [7:0] MAX = FIELD_MAX_BCD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  input  logic       wrap_en,
  input  logic       load,
  input  logic [7:0] val,
  output logic [7:0] q,
  output logic       carry,
  output logic       borrow,
  output logic       is_zero
);

  logic [7:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= BCD_ZERO;
    end else if (load) begin
      r_q <= bcd_clamp(val, MAX);
    end else if (wrap_en && inc) begin
      r_q <= bcd_inc(r_q, MAX);
    end else if (wrap_en && dec) begin
      r_q <= bcd_dec(r_q, MAX);
    end
  end

  assign q       = r_q;
  assign carry   = (r_q == MAX);
  assign borrow  = (r_q == BCD_ZERO);
  assign is_zero = (r_q == BCD_ZERO);

endmodule

// File: rtl/bcd_time_counter.sv
// Cascaded BCD time counter (SS, MM[, HH]) driven by tick enables:
// up/down counting, per-field adjust, parallel load, done and wrap flags.
module bcd_time_counter
  import bcd_time_pkg::*;
#(
  parameter int NUM_FIELDS = 2,
  parameter int TOP_MAX    = 59,
  parameter int SELW       = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick_1hz,
  input  logic                    tick_2hz,
  input  logic                    pause_p,
  input  logic                    adj,
  input  logic [SELW-1:0]         sel,
  input  logic                    down,
  input  logic                    load,
  input  logic [8*NUM_FIELDS-1:0] load_val,
  output logic [8*NUM_FIELDS-1:0] digits,
  output logic                    run,
  output logic                    done,
  output logic                    wrap
);

  localparam logic [7:0] TOP_MAX_BCD = to_bcd(TOP_MAX);

  logic                    r_run;
  logic                    r_done;
  logic                    r_wrap;

  logic                    w_count_en;
  logic                    w_adj_en;
  logic                    w_all_zero;
  logic                    w_upper_zero;
  logic                    w_one_left;
  logic                    w_hit_zero;
  logic [NUM_FIELDS:0]     w_chain;
  logic [NUM_FIELDS-1:0]   w_inc;
  logic [NUM_FIELDS-1:0]   w_dec;
  logic [NUM_FIELDS-1:0]   w_cin;
  logic [NUM_FIELDS-1:0]   w_carry;
  logic [NUM_FIELDS-1:0]   w_borrow;
  logic [NUM_FIELDS-1:0]   w_zero;
  logic [8*NUM_FIELDS-1:0] w_digits;

  // Load outranks adjust, adjust outranks counting; run gates counting only.
  assign w_count_en = tick_1hz && r_run && !adj && !load;
  assign w_adj_en   = tick_2hz && adj && !load;

  assign w_all_zero   = &w_zero;
  assign w_upper_zero = &w_zero[NUM_FIELDS-1:1];
  assign w_one_left   = (w_digits[8*SEC +: 8] == 8'h01) && w_upper_zero;

  // A down tick either lands on all-zero, or arrives at an all-zero value
  // that was loaded rather than counted into.
  assign w_hit_zero = w_count_en && down && (w_one_left || (w_all_zero && !r_done));

  // Ripple enable: field g steps when every field below it rolls over.
  always_comb begin
    w_chain[0] = 1'b1;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      w_chain[i+1] = w_chain[i] && (down ? w_borrow[i] : w_carry[i]);
    end
  end

  for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_field
    assign w_inc[g] = adj ? (w_adj_en && (sel == SELW'(g))) : (w_count_en && !down);
    assign w_dec[g] = w_count_en && down && !w_all_zero;
    assign w_cin[g] = adj ? 1'b1 : w_chain[g];

    bcd_field #(
      .MAX((g == NUM_FIELDS - 1) ? TOP_MAX_BCD : FIELD_MAX_BCD)
    ) u_field (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (w_inc[g]),
      .dec     (w_dec[g]),
      .wrap_en (w_cin[g]),
      .load    (load),
      .val     (load_val[8*g +: 8]),
      .q       (w_digits[8*g +: 8]),
      .carry   (w_carry[g]),
      .borrow  (w_borrow[g]),
      .is_zero (w_zero[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_run  <= 1'b1;
      r_done <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_count_en && !down && w_chain[NUM_FIELDS];

      if (load) begin
        r_done <= 1'b0;
      end else if (w_hit_zero) begin
        r_done <= 1'b1;
      end

      if (w_hit_zero) begin
        r_run <= 1'b0;
      end else if (pause_p) begin
        r_run <= ~r_run;
      end
    end
  end

  assign digits = w_digits;
  assign run    = r_run;
  assign done   = r_done;
  assign wrap   = r_wrap;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: a seconds-total model checked every cycle on
// the 2-field instance, plus literal checks on both 2- and 3-field instances.
module tb_bcd_time_counter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        tick_1hz, tick_2hz, pause_p, adj, down, load;
  logic [1:0]  sel;
  logic [15:0] load_val;
  logic [15:0] digits;
  logic        run, done, wrap;

  logic        b_tick, b_load, b_idle;
  logic [1:0]  b_sel;
  logic [23:0] b_load_val;
  logic [23:0] b_digits;
  logic        b_run, b_done, b_wrap;

  bcd_time_counter #(.NUM_FIELDS(2), .TOP_MAX(59), .SELW(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .pause_p(pause_p), .adj(adj), .sel(sel), .down(down), .load(load),
    .load_val(load_val), .digits(digits), .run(run), .done(done), .wrap(wrap)
  );

  bcd_time_counter #(.NUM_FIELDS(3), .TOP_MAX(23), .SELW(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick_1hz(b_tick), .tick_2hz(b_idle),
    .pause_p(b_idle), .adj(b_idle), .sel(b_sel), .down(b_idle), .load(b_load),
    .load_val(b_load_val), .digits(b_digits), .run(b_run), .done(b_done), .wrap(b_wrap)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (total seconds) ----------------
  int m_tot;
  bit m_run, m_done, m_wrap;
  bit cmp_en = 1'b0;

  function automatic int clamp_dec(input logic [7:0] b, input int max);
    int t, o, d;
    t = int'(b[7:4]);
    o = int'(b[3:0]);
    if (t > 9 || o > 9) return max;
    d = t * 10 + o;
    return (d > max) ? max : d;
  endfunction

  function automatic logic [15:0] to_digits(input int tot);
    logic [15:0] r;
    int s, m;
    s = tot % 60;
    m = tot / 60;
    r = {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    return r;
  endfunction

  always @(posedge clk) begin : model
    bit old_run;
    int fs, fm;
    if (!rst_n) begin
      m_tot = 0; m_run = 1'b1; m_done = 1'b0; m_wrap = 1'b0;
    end else begin
      old_run = m_run;
      m_wrap  = 1'b0;
      if (pause_p) m_run = !m_run;
      if (load) begin
        m_tot  = clamp_dec(load_val[15:8], 59) * 60 + clamp_dec(load_val[7:0], 59);
        m_done = 1'b0;
      end else if (adj) begin
        if (tick_2hz && sel < 2) begin
          fs = m_tot % 60;
          fm = m_tot / 60;
          if (sel == 0) fs = (fs == 59) ? 0 : fs + 1;
          else          fm = (fm == 59) ? 0 : fm + 1;
          m_tot = fm * 60 + fs;
        end
      end else if (tick_1hz && old_run) begin
        if (!down) begin
          m_tot  = (m_tot + 1) % 3600;
          m_wrap = (m_tot == 0);
        end else if (m_tot != 0) begin
          m_tot = m_tot - 1;
          if (m_tot == 0) begin m_done = 1'b1; m_run = 1'b0; end
        end else if (!m_done) begin
          m_done = 1'b1; m_run = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    if (cmp_en) begin
      chk("model_digits", 32'(digits), 32'(to_digits(m_tot)));
      chk("model_run",    32'(run),    32'(m_run));
      chk("model_done",   32'(done),   32'(m_done));
      chk("model_wrap",   32'(wrap),   32'(m_wrap));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse(input bit t1, input bit t2, input bit p, input bit ld, input logic [15:0] v);
    @(negedge clk);
    tick_1hz = t1; tick_2hz = t2; pause_p = p; load = ld;
    if (ld) load_val = v;
    @(negedge clk);
    tick_1hz = 1'b0; tick_2hz = 1'b0; pause_p = 1'b0; load = 1'b0;
  endtask

  task automatic b_pulse(input bit t, input bit ld, input logic [23:0] v);
    @(negedge clk);
    b_tick = t; b_load = ld;
    if (ld) b_load_val = v;
    @(negedge clk);
    b_tick = 1'b0; b_load = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    tick_1hz = 1'b0; tick_2hz = 1'b0; pause_p = 1'b0; adj = 1'b0;
    down = 1'b0; load = 1'b0; sel = 2'd0; load_val = 16'h0;
    b_tick = 1'b0; b_load = 1'b0; b_idle = 1'b0; b_sel = 2'd0; b_load_val = 24'h0;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_run",    32'(run),    32'h1);
    chk("rst_done",   32'(done),   32'h0);
    chk("rst_wrap",   32'(wrap),   32'h0);
    chk("rst_b_digits", 32'(b_digits), 32'h0);
    chk("rst_b_run",    32'(b_run),    32'h1);
    cmp_en = 1'b1;

    // up rollover with a single-cycle wrap pulse
    pulse(0, 0, 0, 1, 16'h5958);
    chk("up_load", 32'(digits), 32'h5958);
    pulse(1, 0, 0, 0, 16'h0);
    chk("up_5959", 32'(digits), 32'h5959);
    chk("up_nowrap", 32'(wrap), 32'h0);
    pulse(1, 0, 0, 0, 16'h0);
    chk("up_roll", 32'(digits), 32'h0000);
    chk("up_wrap", 32'(wrap), 32'h1);
    @(negedge clk);
    chk("up_wrap_clear", 32'(wrap), 32'h0);

    // carry into minutes, borrow from minutes
    pulse(0, 0, 0, 1, 16'h0959);
    pulse(1, 0, 0, 0, 16'h0);
    chk("carry", 32'(digits), 32'h1000);
    down = 1'b1;
    pulse(0, 0, 0, 1, 16'h1000);
    pulse(1, 0, 0, 0, 16'h0);
    chk("borrow", 32'(digits), 32'h0959);

    // countdown to done
    pulse(0, 0, 0, 1, 16'h0002);
    chk("dn_done0", 32'(done), 32'h0);
    pulse(1, 0, 0, 0, 16'h0);
    chk("dn_0001", 32'(digits), 32'h0001);
    pulse(1, 0, 0, 0, 16'h0);
    chk("dn_zero", 32'(digits), 32'h0000);
    chk("dn_done", 32'(done), 32'h1);
    chk("dn_run",  32'(run),  32'h0);
    pulse(1, 0, 0, 0, 16'h0);
    chk("dn_hold", 32'(digits), 32'h0000);

    // adjust minutes with concurrent 1 Hz ticks
    adj = 1'b1; sel = 2'd1;
    pulse(0, 0, 0, 1, 16'h5830);
    chk("adj_load", 32'(digits), 32'h5830);
    chk("adj_done_clr", 32'(done), 32'h0);
    pulse(0, 0, 1, 0, 16'h0);
    chk("adj_run", 32'(run), 32'h1);
    pulse(1, 1, 0, 0, 16'h0);
    chk("adj_5930", 32'(digits), 32'h5930);
    pulse(1, 1, 0, 0, 16'h0);
    pulse(1, 1, 0, 0, 16'h0);
    chk("adj_0130", 32'(digits), 32'h0130);
    sel = 2'd2;
    pulse(0, 1, 0, 0, 16'h0);
    chk("adj_badsel", 32'(digits), 32'h0130);
    adj = 1'b0;
    pulse(0, 1, 0, 0, 16'h0);
    chk("t2_noadj", 32'(digits), 32'h0130);

    // pause together with a tick uses the old run value
    down = 1'b0;
    pulse(0, 0, 0, 1, 16'h0000);
    pulse(1, 0, 1, 0, 16'h0);
    chk("pause_cnt", 32'(digits), 32'h0001);
    chk("pause_run", 32'(run), 32'h0);
    pulse(1, 0, 0, 0, 16'h0);
    chk("pause_hold", 32'(digits), 32'h0001);

    // all-zero load while counting down: done waits for a tick
    down = 1'b1;
    pulse(0, 0, 0, 1, 16'h0000);
    chk("zld_done0", 32'(done), 32'h0);
    pulse(0, 0, 1, 0, 16'h0);
    pulse(1, 0, 0, 0, 16'h0);
    chk("zld_done1", 32'(done), 32'h1);
    chk("zld_digits", 32'(digits), 32'h0000);
    down = 1'b0;

    // load clamping on the 2-field instance
    pulse(0, 0, 0, 1, 16'h6A5B);
    chk("clamp_a1", 32'(digits), 32'h5959);
    pulse(0, 0, 0, 1, 16'h7012);
    chk("clamp_a2", 32'(digits), 32'h5912);

    // 3-field instance, TOP_MAX=23
    b_pulse(0, 1, 24'h997A05);
    chk("clamp_b", 32'(b_digits), 32'h235905);
    b_pulse(0, 1, 24'h005959);
    b_pulse(1, 0, 24'h0);
    chk("b_carry2", 32'(b_digits), 32'h010000);
    b_pulse(0, 1, 24'h235959);
    b_pulse(1, 0, 24'h0);
    chk("b_roll", 32'(b_digits), 32'h000000);
    chk("b_wrap", 32'(b_wrap), 32'h1);

    // mixed directed/random traffic against the model
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      tick_1hz = ($urandom_range(0, 2) == 0);
      tick_2hz = ($urandom_range(0, 2) == 0);
      pause_p  = ($urandom_range(0, 15) == 0);
      load     = ($urandom_range(0, 23) == 0);
      case ($urandom_range(0, 4))
        0: load_val = 16'h5959;
        1: load_val = 16'h0001;
        2: load_val = 16'h5958;
        3: load_val = 16'h0000;
        default: load_val = 16'($urandom_range(0, 65535));
      endcase
      if ($urandom_range(0, 15) == 0) adj = ~adj;
      if ($urandom_range(0, 7) == 0) down = ~down;
      sel = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    tick_1hz = 1'b0; tick_2hz = 1'b0; pause_p = 1'b0; load = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
